// File: rtl/pacman_move_ctrl_if.sv
// Link between the Pac-Man move controller and the position datapath/maze.
// Carries position feedback, the wall lookup bus and the move/reload pulses.
interface pacman_move_ctrl_if;
  logic [9:0] xPacLoc;
  logic [8:0] yPacLoc;
  logic       wall_rd_en;
  logic [9:0] wall_rd_x;
  logic [8:0] wall_rd_y;
  logic       wall_is_wall;
  logic       e_start;
  logic       m_up;
  logic       m_down;
  logic       m_left;
  logic       m_right;

  modport master (
    input  xPacLoc, yPacLoc, wall_is_wall,
    output wall_rd_en, wall_rd_x, wall_rd_y,
    output e_start, m_up, m_down, m_left, m_right
  );

  modport slave (
    output xPacLoc, yPacLoc, wall_is_wall,
    input  wall_rd_en, wall_rd_x, wall_rd_y,
    input  e_start, m_up, m_down, m_left, m_right
  );
endinterface

// File: rtl/pacman_move_ctrl.sv
// Pac-Man move control: latches key direction, probes walls each tick and
// issues one move or reload pulse. Ports: clk, reset, start, key_*, dp, cur_dir.
module pacman_move_ctrl #(
  parameter int WIDTH       = 96,
  parameter int HEIGHT      = 72,
  parameter int TICK_CYCLES = 500000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      key_up,
  input  logic                      key_down,
  input  logic                      key_left,
  input  logic                      key_right,
  pacman_move_ctrl_if.master        dp,
  output logic [1:0]                cur_dir
);

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam logic [9:0] XMAX = 10'(WIDTH);
  localparam logic [8:0] YMAX = 9'(HEIGHT);

  localparam int CW = $clog2(TICK_CYCLES);
  localparam logic [CW-1:0] CLAST = CW'(TICK_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE,
    INIT,
    WAIT_TICK,
    PROBE_REQ,
    CHK_REQ,
    PROBE_CUR,
    CHK_CUR,
    MOVE,
    SETTLE1,
    SETTLE2
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [CW-1:0]   cnt;
  logic [1:0]      req_dir;
  logic [1:0]      probe_dir;
  logic            probe_ok;
  logic [9:0]      rd_x;
  logic [8:0]      rd_y;
  logic            tick_hit;
  logic            pos_ok;

  // Neighbour cell with toroidal wrap; the datapath applies the same wrap.
  function automatic logic [18:0] step(
    input logic [1:0] d,
    input logic [9:0] x,
    input logic [8:0] y
  );
    logic [9:0] nx;
    logic [8:0] ny;
    nx = x;
    ny = y;
    case (d)
      DIR_UP:   ny = (y == 9'd1) ? YMAX : y - 9'd1;
      DIR_DOWN: ny = (y == YMAX) ? 9'd1 : y + 9'd1;
      DIR_LEFT: nx = (x == 10'd1) ? XMAX : x - 10'd1;
      default:  nx = (x == XMAX) ? 10'd1 : x + 10'd1;
    endcase
    return {nx, ny};
  endfunction

  assign tick_hit = (cnt == CLAST);

  assign pos_ok = (dp.xPacLoc >= 10'd1) && (dp.xPacLoc <= XMAX) &&
                  (dp.yPacLoc >= 9'd1)  && (dp.yPacLoc <= YMAX);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (start) state_n = INIT;
      INIT:      state_n = WAIT_TICK;
      WAIT_TICK: if (tick_hit) state_n = PROBE_REQ;
      PROBE_REQ: state_n = probe_ok ? CHK_REQ : SETTLE1;
      CHK_REQ: begin
        if (!dp.wall_is_wall)        state_n = MOVE;
        else if (probe_dir == cur_dir) state_n = SETTLE1;
        else                         state_n = PROBE_CUR;
      end
      PROBE_CUR: state_n = CHK_CUR;
      CHK_CUR:   state_n = dp.wall_is_wall ? SETTLE1 : MOVE;
      MOVE:      state_n = SETTLE1;
      SETTLE1:   state_n = SETTLE2;
      SETTLE2:   state_n = WAIT_TICK;
      default:   state_n = IDLE;
    endcase
    // Restart wins over everything, aborting any probe in flight.
    if (start && state != IDLE) state_n = INIT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      req_dir   <= DIR_LEFT;
      cur_dir   <= DIR_LEFT;
      probe_dir <= DIR_LEFT;
      probe_ok  <= 1'b0;
      rd_x      <= '0;
      rd_y      <= '0;
    end else begin
      // Counter free-runs outside IDLE/INIT so the tick period never drifts.
      if (state == INIT)      cnt <= '0;
      else if (state != IDLE) cnt <= tick_hit ? '0 : cnt + CW'(1);

      if (state == INIT)  req_dir <= DIR_LEFT;
      else if (key_up)    req_dir <= DIR_UP;
      else if (key_down)  req_dir <= DIR_DOWN;
      else if (key_left)  req_dir <= DIR_LEFT;
      else if (key_right) req_dir <= DIR_RIGHT;

      if (state == INIT)
        cur_dir <= DIR_LEFT;
      else if (state == CHK_REQ && state_n == MOVE)
        cur_dir <= probe_dir;

      // Freeze the request at the tick so later keys hit the next tick.
      if (state_n == PROBE_REQ) begin
        probe_dir <= req_dir;
        probe_ok  <= pos_ok;
        if (pos_ok)
          {rd_x, rd_y} <= step(req_dir, dp.xPacLoc, dp.yPacLoc);
      end else if (state_n == PROBE_CUR) begin
        {rd_x, rd_y} <= step(cur_dir, dp.xPacLoc, dp.yPacLoc);
      end
    end
  end

  assign dp.wall_rd_x  = rd_x;
  assign dp.wall_rd_y  = rd_y;
  assign dp.wall_rd_en = (state == PROBE_REQ && probe_ok) ||
                         (state == PROBE_CUR);
  assign dp.e_start    = (state == INIT);
  assign dp.m_up       = (state == MOVE) && (cur_dir == DIR_UP);
  assign dp.m_down     = (state == MOVE) && (cur_dir == DIR_DOWN);
  assign dp.m_left     = (state == MOVE) && (cur_dir == DIR_LEFT);
  assign dp.m_right    = (state == MOVE) && (cur_dir == DIR_RIGHT);

endmodule

// File: tb/tb_pacman_move_ctrl.sv
// Scoreboard bench for pacman_move_ctrl: stimulus queues expected events,
// a negedge monitor pops and compares every pulse and lookup.
module tb_pacman_move_ctrl;

  localparam int EV_START = 0;
  localparam int EV_LOOK  = 1;
  localparam int EV_UP    = 2;
  localparam int EV_DOWN  = 3;
  localparam int EV_LEFT  = 4;
  localparam int EV_RIGHT = 5;

  typedef struct {
    int kind;
    int x;
    int y;
    int cyc;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic key_up = 1'b0;
  logic key_down = 1'b0;
  logic key_left = 1'b0;
  logic key_right = 1'b0;
  logic [1:0] cur_dir;

  pacman_move_ctrl_if bus ();

  pacman_move_ctrl #(
    .WIDTH(96),
    .HEIGHT(72),
    .TICK_CYCLES(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .key_up(key_up),
    .key_down(key_down),
    .key_left(key_left),
    .key_right(key_right),
    .dp(bus),
    .cur_dir(cur_dir)
  );

  always #5 clk = ~clk;

  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  ev_t exp_q[$];
  bit  walls[int];

  always @(posedge clk) cyc <= cyc + 1;

  // Maze model: one-cycle-latency wall lookup.
  initial bus.wall_is_wall = 1'b0;
  always @(posedge clk)
    bus.wall_is_wall <= bus.wall_rd_en &&
      walls.exists(int'(bus.wall_rd_x) * 1024 + int'(bus.wall_rd_y));

  function automatic string kname(input int k);
    case (k)
      EV_START: return "e_start";
      EV_LOOK:  return "lookup";
      EV_UP:    return "m_up";
      EV_DOWN:  return "m_down";
      EV_LEFT:  return "m_left";
      default:  return "m_right";
    endcase
  endfunction

  task automatic push(input int k, input int x, input int y, input int c);
    ev_t e;
    e.kind = k;
    e.x = x;
    e.y = y;
    e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic got(input int k, input int x, input int y);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected %s (%0d,%0d) at cyc %0d, required none",
               kname(k), x, y, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.x != x || e.y != y || e.cyc != cyc) begin
        errors++;
        $display("FAIL event: got %s (%0d,%0d) @%0d, required %s (%0d,%0d) @%0d",
                 kname(k), x, y, cyc, kname(e.kind), e.x, e.y, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL missing %s (%0d,%0d) due @%0d, not observed by cyc %0d",
               kname(exp_q[0].kind), exp_q[0].x, exp_q[0].y,
               exp_q[0].cyc, cyc);
      void'(exp_q.pop_front());
    end
    if (bus.e_start) got(EV_START, 0, 0);
    if (bus.wall_rd_en)
      got(EV_LOOK, int'(bus.wall_rd_x), int'(bus.wall_rd_y));
    if (bus.m_up || bus.m_down || bus.m_left || bus.m_right) begin
      checks++;
      if ($countones({bus.m_up, bus.m_down, bus.m_left, bus.m_right}) != 1) begin
        errors++;
        $display("FAIL onehot: moves=%b, required one-hot",
                 {bus.m_up, bus.m_down, bus.m_left, bus.m_right});
      end
      if (bus.m_up)    got(EV_UP, 0, 0);
      if (bus.m_down)  got(EV_DOWN, 0, 0);
      if (bus.m_left)  got(EV_LEFT, 0, 0);
      if (bus.m_right) got(EV_RIGHT, 0, 0);
    end
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Returns at posedge k plus 1 time unit.
  task automatic wait_cyc(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input int k);
    wait_cyc(k);
    start = 1'b1;
    wait_cyc(k + 1);
    start = 1'b0;
  endtask

  task automatic set_pos(input int x, input int y);
    bus.xPacLoc = 10'(x);
    bus.yPacLoc = 9'(y);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: run exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    set_pos(46, 7);
    repeat (3) @(posedge clk);
    #1;
    check("rst_e_start", int'(bus.e_start), 0);
    check("rst_rd_en", int'(bus.wall_rd_en), 0);
    check("rst_rd_x", int'(bus.wall_rd_x), 0);
    check("rst_rd_y", int'(bus.wall_rd_y), 0);
    check("rst_moves", int'({bus.m_up, bus.m_down, bus.m_left, bus.m_right}), 0);
    check("rst_cur_dir", int'(cur_dir), 2);
    reset = 1'b0;

    // Open maze, heading left from (46,7): move every 16 cycles.
    c = cyc + 2;
    push(EV_START, 0, 0, c + 1);
    push(EV_LOOK, 45, 7, c + 18);
    push(EV_LEFT, 0, 0, c + 20);
    push(EV_LOOK, 45, 7, c + 34);
    push(EV_LEFT, 0, 0, c + 36);
    pulse_start(c);
    wait_cyc(c + 40);
    check("open_cur_dir", int'(cur_dir), 2);

    // Buffered turn: up blocked, keep left; up later opens.
    c = cyc + 2;
    walls[46 * 1024 + 6] = 1'b1;
    push(EV_START, 0, 0, c + 1);
    push(EV_LOOK, 46, 6, c + 18);
    push(EV_LOOK, 45, 7, c + 20);
    push(EV_LEFT, 0, 0, c + 22);
    push(EV_LOOK, 46, 6, c + 34);
    push(EV_UP, 0, 0, c + 36);
    push(EV_LOOK, 46, 6, c + 50);
    push(EV_UP, 0, 0, c + 52);
    pulse_start(c);
    wait_cyc(c + 5);
    key_up = 1'b1;
    wait_cyc(c + 6);
    key_up = 1'b0;
    wait_cyc(c + 23);
    check("blocked_cur_dir", int'(cur_dir), 2);
    walls.delete(46 * 1024 + 6);
    wait_cyc(c + 37);
    check("turn_cur_dir", int'(cur_dir), 0);
    wait_cyc(c + 55);

    // Wrap on all four edges.
    c = cyc + 2;
    set_pos(1, 7);
    push(EV_START, 0, 0, c + 1);
    push(EV_LOOK, 96, 7, c + 18);
    push(EV_LEFT, 0, 0, c + 20);
    push(EV_LOOK, 5, 1, c + 34);
    push(EV_DOWN, 0, 0, c + 36);
    push(EV_LOOK, 5, 72, c + 50);
    push(EV_UP, 0, 0, c + 52);
    push(EV_LOOK, 1, 30, c + 66);
    push(EV_RIGHT, 0, 0, c + 68);
    pulse_start(c);
    wait_cyc(c + 22);
    key_down = 1'b1;
    wait_cyc(c + 23);
    key_down = 1'b0;
    set_pos(5, 72);
    wait_cyc(c + 40);
    key_up = 1'b1;
    wait_cyc(c + 41);
    key_up = 1'b0;
    set_pos(5, 1);
    wait_cyc(c + 56);
    key_right = 1'b1;
    wait_cyc(c + 57);
    key_right = 1'b0;
    set_pos(96, 30);
    wait_cyc(c + 71);
    check("wrap_cur_dir", int'(cur_dir), 3);

    // Both directions walled: stop, probe again every tick.
    c = cyc + 2;
    set_pos(46, 7);
    walls[46 * 1024 + 6] = 1'b1;
    walls[45 * 1024 + 7] = 1'b1;
    push(EV_START, 0, 0, c + 1);
    push(EV_LOOK, 46, 6, c + 18);
    push(EV_LOOK, 45, 7, c + 20);
    push(EV_LOOK, 46, 6, c + 34);
    push(EV_LOOK, 45, 7, c + 36);
    push(EV_LOOK, 45, 7, c + 50);
    push(EV_LOOK, 45, 7, c + 66);
    pulse_start(c);
    wait_cyc(c + 5);
    key_up = 1'b1;
    wait_cyc(c + 6);
    key_up = 1'b0;
    wait_cyc(c + 38);
    check("stuck_cur_dir", int'(cur_dir), 2);
    key_left = 1'b1;
    wait_cyc(c + 41);
    key_left = 1'b0;
    wait_cyc(c + 70);
    walls.delete();

    // Restart during CHK_REQ: no move, tick counter restarts.
    c = cyc + 2;
    push(EV_START, 0, 0, c + 1);
    push(EV_LOOK, 45, 7, c + 18);
    push(EV_START, 0, 0, c + 20);
    push(EV_LOOK, 45, 7, c + 37);
    push(EV_LEFT, 0, 0, c + 39);
    pulse_start(c);
    pulse_start(c + 19);
    wait_cyc(c + 42);
    check("restart_cur_dir", int'(cur_dir), 2);

    wait_cyc(cyc + 4);
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
